// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_tracker
//  Purpose  : Decodes a PS/2 scan-code byte stream (set 2) into held key
//             state for a small set of tracked keys. It emits press/release
//             pulses and remembers which tracked key was pressed last.
//  Revision : 1.0 - initial release
//
//  Ports
//    clock        in   1         system clock, rising edge
//    reset        in   1         asynchronous, active-high reset
//    scan_code    in   8         byte from PS/2 receiver
//    scan_ready   in   1         receiver byte-valid level
//    read         out  1         one-cycle acknowledge to receiver
//    key_down     out  NUM_KEYS  held state per channel
//    key_press    out  NUM_KEYS  one-cycle pulse on up->down
//    key_release  out  NUM_KEYS  one-cycle pulse on down->up
//    any_down     out  1         OR of key_down
//    last_key     out  IDXW      most recently pressed channel
//
//  Build option
//    PS2_KEY_TRACKER_EXT_EN : enables E0-prefixed (extended) decoding and
//                             KEY_EXT_MASK. When it is undefined, E0 is
//                             acknowledged and then ignored.
// ============================================================================
module ps2_key_tracker #(
  parameter int                      NUM_KEYS       = 4,
  // Channel 0 lives in the low byte: ch0=14, ch1=1B, ch2=1D, ch3=2D.
  parameter logic [8*NUM_KEYS-1:0]   KEY_CODES      = {8'h2D, 8'h1D, 8'h1B, 8'h14},
  parameter logic [NUM_KEYS-1:0]     KEY_EXT_MASK   = '0,
  parameter int                      TIMEOUT_CYCLES = 50000,
  parameter int                      IDXW           = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          scan_code,
  input  logic                scan_ready,
  output logic                read,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_down,
  output logic [IDXW-1:0]     last_key
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_KEY_TRACKER_EXT_EN
  localparam bit EXT_ENABLED = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, BRK = 2'd1, EXT = 2'd2, EXT_BRK = 2'd3} state_t;
`else
  localparam bit EXT_ENABLED = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, BRK = 2'd1} state_t;
`endif

  // With extended decoding disabled every channel behaves as unprefixed.
  localparam logic [NUM_KEYS-1:0] EFF_MASK = KEY_EXT_MASK & {NUM_KEYS{EXT_ENABLED}};

  state_t                r_state, w_next_state;
  logic                  r_ready_q;
  logic [CW-1:0]         r_cnt;
  logic                  w_accept;
  logic                  w_tmo;
  logic                  w_make;
  logic                  w_brk;
  logic                  w_ext;
  logic [NUM_KEYS-1:0]   w_hit;
  logic [IDXW-1:0]       w_idx;

  // A byte is taken only on a fresh rising edge of scan_ready and never
  // during the acknowledge cycle.
  assign w_accept = scan_ready & ~r_ready_q & ~read;
  assign w_tmo    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign any_down = |key_down;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ready_q <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_ready_q <= scan_ready;
    end
  end

  // Next-state and byte classification. The accepted byte is decoded
  // straight from scan_code so the key outputs update one cycle after the
  // byte is accepted, while read is high.
  always_comb begin
    w_next_state = r_state;
    w_make       = 1'b0;
    w_brk        = 1'b0;
    w_ext        = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (scan_code == 8'hE0) begin
`ifdef PS2_KEY_TRACKER_EXT_EN
            w_next_state = EXT;
`else
            w_next_state = IDLE;
`endif
          end else if (scan_code == 8'hF0) begin
            w_next_state = BRK;
          end else begin
            w_make = 1'b1;
          end
        end
        BRK: begin
`ifdef PS2_KEY_TRACKER_EXT_EN
          w_brk        = 1'b1;
          w_next_state = IDLE;
`else
          // E0 is dropped silently; the break target is still pending.
          if (scan_code != 8'hE0) begin
            w_brk        = 1'b1;
            w_next_state = IDLE;
          end
`endif
        end
`ifdef PS2_KEY_TRACKER_EXT_EN
        EXT: begin
          if (scan_code == 8'hF0) begin
            w_next_state = EXT_BRK;
          end else if (scan_code != 8'hE0) begin
            w_make       = 1'b1;
            w_ext        = 1'b1;
            w_next_state = IDLE;
          end
        end
        EXT_BRK: begin
          w_brk        = 1'b1;
          w_ext        = 1'b1;
          w_next_state = IDLE;
        end
`endif
        default: w_next_state = IDLE;
      endcase
    end else if (r_state != IDLE && w_tmo) begin
      w_next_state = IDLE;
    end
  end

  // Channel match, scanning downward so the lowest index wins on duplicates.
  always_comb begin
    w_hit = '0;
    w_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (scan_code == KEY_CODES[8*i +: 8] && EFF_MASK[i] == w_ext) begin
        w_hit    = '0;
        w_hit[i] = 1'b1;
        w_idx    = IDXW'(i);
      end
    end
  end

  // Prefix timeout: counts only while a prefix is pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept || r_state == IDLE || w_tmo) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read        <= 1'b0;
      key_down    <= '0;
      key_press   <= '0;
      key_release <= '0;
      last_key    <= '0;
    end else begin
      read        <= w_accept;
      key_press   <= '0;
      key_release <= '0;
      // Typematic repeats of an already-held key are ignored.
      if (w_make && (|w_hit) && ((key_down & w_hit) == '0)) begin
        key_down  <= key_down | w_hit;
        key_press <= w_hit;
        last_key  <= w_idx;
      end
      if (w_brk && ((key_down & w_hit) != '0)) begin
        key_down    <= key_down & ~w_hit;
        key_release <= w_hit;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_tracker
//  Purpose  : Self-checking bench for ps2_key_tracker. Each byte sent pushes
//             its expected key state to a scoreboard. The entry is popped and
//             compared once the DUT acknowledges the byte.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       read;
  logic [3:0] key_down, key_press, key_release;
  logic       any_down;
  logic [1:0] last_key;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    logic [3:0] down;
    logic [3:0] press;
    logic [3:0] rel;
    logic [1:0] last;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  ps2_key_tracker #(
    .NUM_KEYS      (4),
    .KEY_CODES     ({8'h2D, 8'h1D, 8'h1B, 8'h14}),
    .KEY_EXT_MASK  (4'b0001),
    .TIMEOUT_CYCLES(20),
    .IDXW          (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_code  (scan_code),
    .scan_ready (scan_ready),
    .read       (read),
    .key_down   (key_down),
    .key_press  (key_press),
    .key_release(key_release),
    .any_down   (any_down),
    .last_key   (last_key)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic [3:0] down,
                           input logic [3:0] press, input logic [3:0] rel,
                           input logic [1:0] last);
    exp_t e;
    bit   got;
    e.code = b; e.down = down; e.press = press; e.rel = rel; e.last = last;
    sb.push_back(e);
    @(negedge clock);
    scan_code  = b;
    scan_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge clock);
      #1;
      if (read) got = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL read_ack byte %h: read=0, required 1 within 4 cycles", e.code);
    end else begin
      checks += 5;
      if (key_down !== e.down) begin
        errors++; $display("FAIL key_down byte %h: got %b want %b", e.code, key_down, e.down);
      end
      if (key_press !== e.press) begin
        errors++; $display("FAIL key_press byte %h: got %b want %b", e.code, key_press, e.press);
      end
      if (key_release !== e.rel) begin
        errors++; $display("FAIL key_release byte %h: got %b want %b", e.code, key_release, e.rel);
      end
      if (last_key !== e.last) begin
        errors++; $display("FAIL last_key byte %h: got %0d want %0d", e.code, last_key, e.last);
      end
      if (any_down !== (|e.down)) begin
        errors++; $display("FAIL any_down byte %h: got %b want %b", e.code, any_down, |e.down);
      end
    end
    @(negedge clock);
    scan_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (key_down !== 4'b0 || read !== 1'b0 || last_key !== 2'd0 ||
        key_press !== 4'b0 || key_release !== 4'b0 || any_down !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: down=%b press=%b rel=%b read=%b last=%0d any=%b, want all 0",
               key_down, key_press, key_release, read, last_key, any_down);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    scan_code  = 8'h00;
    scan_ready = 1'b0;
    reset      = 1'b0;
    pulse_reset();
  endtask

  task automatic test_make_break();
    send_byte(8'h1D, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    send_byte(8'hF0, 4'b0100, 4'b0000, 4'b0000, 2'd2);
    send_byte(8'h1D, 4'b0000, 4'b0000, 4'b0100, 2'd2);
  endtask

  task automatic test_repeat();
    send_byte(8'h1B, 4'b0010, 4'b0010, 4'b0000, 2'd1);
    send_byte(8'h1B, 4'b0010, 4'b0000, 4'b0000, 2'd1);
    send_byte(8'h1B, 4'b0010, 4'b0000, 4'b0000, 2'd1);
    send_byte(8'hF0, 4'b0010, 4'b0000, 4'b0000, 2'd1);
    send_byte(8'h1B, 4'b0000, 4'b0000, 4'b0010, 2'd1);
  endtask

  task automatic test_multi();
    send_byte(8'h1D, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    send_byte(8'h1B, 4'b0110, 4'b0010, 4'b0000, 2'd1);
    send_byte(8'hF0, 4'b0110, 4'b0000, 4'b0000, 2'd1);
    send_byte(8'h1D, 4'b0010, 4'b0000, 4'b0100, 2'd1);
    send_byte(8'hF0, 4'b0010, 4'b0000, 4'b0000, 2'd1);
    send_byte(8'h1B, 4'b0000, 4'b0000, 4'b0010, 2'd1);
  endtask

  task automatic test_unknown();
    send_byte(8'h55, 4'b0000, 4'b0000, 4'b0000, 2'd1);
    send_byte(8'hF0, 4'b0000, 4'b0000, 4'b0000, 2'd1);
    send_byte(8'h55, 4'b0000, 4'b0000, 4'b0000, 2'd1);
    // Break for a key that is not held has no effect.
    send_byte(8'hF0, 4'b0000, 4'b0000, 4'b0000, 2'd1);
    send_byte(8'h2D, 4'b0000, 4'b0000, 4'b0000, 2'd1);
  endtask

  task automatic test_timeout();
    send_byte(8'hF0, 4'b0000, 4'b0000, 4'b0000, 2'd1);
    repeat (21) @(negedge clock);
    send_byte(8'h2D, 4'b1000, 4'b1000, 4'b0000, 2'd3);
    send_byte(8'hF0, 4'b1000, 4'b0000, 4'b0000, 2'd3);
    send_byte(8'h2D, 4'b0000, 4'b0000, 4'b1000, 2'd3);
  endtask

  task automatic test_ext();
`ifdef PS2_KEY_TRACKER_EXT_EN
    send_byte(8'h14, 4'b0000, 4'b0000, 4'b0000, 2'd3);
    send_byte(8'hE0, 4'b0000, 4'b0000, 4'b0000, 2'd3);
    send_byte(8'h14, 4'b0001, 4'b0001, 4'b0000, 2'd0);
    send_byte(8'hE0, 4'b0001, 4'b0000, 4'b0000, 2'd0);
    send_byte(8'hF0, 4'b0001, 4'b0000, 4'b0000, 2'd0);
    send_byte(8'h14, 4'b0000, 4'b0000, 4'b0001, 2'd0);
`else
    send_byte(8'h14, 4'b0001, 4'b0001, 4'b0000, 2'd0);
    send_byte(8'hF0, 4'b0001, 4'b0000, 4'b0000, 2'd0);
    send_byte(8'h14, 4'b0000, 4'b0000, 4'b0001, 2'd0);
    send_byte(8'hE0, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    send_byte(8'h14, 4'b0001, 4'b0001, 4'b0000, 2'd0);
    send_byte(8'hE0, 4'b0001, 4'b0000, 4'b0000, 2'd0);
    send_byte(8'hF0, 4'b0001, 4'b0000, 4'b0000, 2'd0);
    send_byte(8'h14, 4'b0000, 4'b0000, 4'b0001, 2'd0);
`endif
  endtask

  task automatic test_long_ready();
    int reads;
    int presses;
    reads   = 0;
    presses = 0;
    @(negedge clock);
    scan_code  = 8'h2D;
    scan_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (read) reads++;
      if (key_press[3]) presses++;
    end
    @(negedge clock);
    scan_ready = 1'b0;
    @(negedge clock);
    checks += 3;
    if (reads != 1) begin
      errors++; $display("FAIL long_ready_reads: got %0d read pulses want 1", reads);
    end
    if (presses != 1) begin
      errors++; $display("FAIL long_ready_press: got %0d press pulses want 1", presses);
    end
    if (key_down !== 4'b1000) begin
      errors++; $display("FAIL long_ready_down: got %b want 1000", key_down);
    end
    // A reset after F0 must drop the pending break.
    send_byte(8'hF0, 4'b1000, 4'b0000, 4'b0000, 2'd3);
    pulse_reset();
    send_byte(8'h2D, 4'b1000, 4'b1000, 4'b0000, 2'd3);
    send_byte(8'hF0, 4'b1000, 4'b0000, 4'b0000, 2'd3);
    send_byte(8'h2D, 4'b0000, 4'b0000, 4'b1000, 2'd3);
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_repeat();
    test_multi();
    test_unknown();
    test_timeout();
    test_ext();
    test_long_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
